// File: rtl/reel_mic_sampler_pkg.sv
// reel_mic_sampler_pkg
//   Shared definitions for the microphone sampler slice: SPI controller
//   state codes, ADC frame geometry, the mid-scale reference and the
//   rectifier used by the envelope tracker.
//   No ports (package).
package reel_mic_sampler_pkg;

  // Controller states, kept as plain constants for legacy compatibility.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // ADC frame: LEAD_ZEROS zero bits, then a 12-bit offset-binary sample.
  localparam int          FRAME_BITS   = 16;
  localparam int          LEAD_ZEROS   = 4;
  localparam logic [11:0] MIC_MIDPOINT = 12'd2048;

  // Distance of a sample from mid-scale. The all-zero code sits 2048 below
  // mid-scale, one step beyond the 11-bit envelope range, so it saturates.
  function automatic logic [10:0] rectify(input logic [11:0] smp);
    logic signed [12:0] diff;
    diff = $signed({1'b0, smp}) - $signed({1'b0, MIC_MIDPOINT});
    if (diff < 13'sd0) begin
      diff = -diff;
    end else begin
      diff = diff;
    end
    if (diff > 13'sd2047) begin
      return 11'h7FF;
    end else begin
      return diff[10:0];
    end
  endfunction

endpackage

// File: rtl/reel_mic_sampler_if.sv
// reel_mic_sampler_if
//   Bundle of the ADC SPI pins and the sampler's result outputs.
//   master : the sampler (drives SPI clock/select and the results)
//   slave  : the ADC side / consumer (drives miso, observes the rest)
//   Signals: spi_miso, spi_cs_n, spi_sclk, sample[11:0], sample_valid,
//            frame_err, reel[8:0]
interface reel_mic_sampler_if;
  logic        spi_miso;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic [11:0] sample;
  logic        sample_valid;
  logic        frame_err;
  logic [8:0]  reel;

  modport master (
    input  spi_miso,
    output spi_cs_n, spi_sclk, sample, sample_valid, frame_err, reel
  );

  modport slave (
    output spi_miso,
    input  spi_cs_n, spi_sclk, sample, sample_valid, frame_err, reel
  );
endinterface

// File: rtl/reel_mic_sampler_envelope.sv
// reel_mic_sampler_envelope
//   Rectifies each accepted sample about mid-scale and keeps a peak-hold
//   envelope that decays by one LSB every DECAY_PERIOD clocks.
//   Ports:
//     clk           system clock
//     rst           synchronous active-low reset
//     sample        latest accepted raw sample (offset binary)
//     sample_valid  pulse: sample has just been updated
//     reel          registered envelope[10:2]
module reel_mic_sampler_envelope
  import reel_mic_sampler_pkg::*;
#(
  parameter int DECAY_PERIOD = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sample,
  input  logic        sample_valid,
  output logic [8:0]  reel
);

  localparam int DEC_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

  logic [DEC_W-1:0] dec_cnt_r;
  logic [10:0]      env_r;
  logic [10:0]      mag_s;
  logic             rise_s;
  logic             tick_s;

  assign mag_s  = rectify(sample);
  assign rise_s = sample_valid && (mag_s > env_r);
  assign tick_s = (dec_cnt_r == DEC_W'(DECAY_PERIOD - 1));

  // Decay timebase, peak-hold envelope and the registered reel output.
  // A rise in the same cycle as a decay tick swallows that tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dec_cnt_r <= {DEC_W{1'b0}};
      env_r     <= 11'd0;
      reel      <= 9'd0;
    end else begin
      if (tick_s) begin
        dec_cnt_r <= {DEC_W{1'b0}};
      end else begin
        dec_cnt_r <= dec_cnt_r + DEC_W'(1);
      end
      if (rise_s) begin
        env_r <= mag_s;
      end else if (tick_s && (env_r != 11'd0)) begin
        env_r <= env_r - 11'd1;
      end else begin
        env_r <= env_r;
      end
      reel <= env_r[10:2];
    end
  end

endmodule

// File: rtl/reel_mic_sampler.sv
// reel_mic_sampler
//   SPI master for a 12-bit serial microphone ADC (CPOL=1, 16-bit frame of
//   four zeros then D11..D0 MSB first). Validates each frame, publishes the
//   raw sample and feeds the envelope tracker that produces `reel`.
//   Ports:
//     clk   system clock
//     rst   synchronous active-low reset
//     bus   master side of reel_mic_sampler_if (SPI pins, sample,
//           sample_valid, frame_err, reel)
module reel_mic_sampler
  import reel_mic_sampler_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int SAMPLE_GAP   = 2000,
  parameter int DECAY_PERIOD = 5000
) (
  input  logic                clk,
  input  logic                rst,
  reel_mic_sampler_if.master  bus
);

  localparam int GAP_W = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
  localparam int HP_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [1:0]            state_r;
  logic [GAP_W-1:0]      gap_cnt_r;
  logic [HP_W-1:0]       hp_cnt_r;
  logic [4:0]            bit_cnt_r;
  logic [FRAME_BITS-1:0] sr_r;
  logic                  cs_n_r;
  logic                  sclk_r;
  logic [11:0]           sample_r;
  logic                  sample_valid_r;
  logic                  frame_err_r;
  logic [8:0]            reel_s;
  logic                  lead_ok_s;

  assign lead_ok_s = (sr_r[FRAME_BITS-1 -: LEAD_ZEROS] == {LEAD_ZEROS{1'b0}});

  // Frame sequencer: gap timing, SCLK generation, bit capture on SCLK
  // rising edges and frame validation in the single DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      gap_cnt_r      <= {GAP_W{1'b0}};
      hp_cnt_r       <= {HP_W{1'b0}};
      bit_cnt_r      <= 5'd0;
      sr_r           <= {FRAME_BITS{1'b0}};
      cs_n_r         <= 1'b1;
      sclk_r         <= 1'b1;
      sample_r       <= MIC_MIDPOINT;
      sample_valid_r <= 1'b0;
      frame_err_r    <= 1'b0;
    end else begin
      sample_valid_r <= 1'b0;
      frame_err_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cs_n_r <= 1'b1;
          sclk_r <= 1'b1;
          if (gap_cnt_r == GAP_W'(SAMPLE_GAP - 1)) begin
            gap_cnt_r <= {GAP_W{1'b0}};
            hp_cnt_r  <= {HP_W{1'b0}};
            bit_cnt_r <= 5'd0;
            cs_n_r    <= 1'b0;
            state_r   <= ST_SHIFT;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        ST_SHIFT: begin
          if (hp_cnt_r == HP_W'(CLK_DIV - 1)) begin
            hp_cnt_r <= {HP_W{1'b0}};
            sclk_r   <= ~sclk_r;
            // sclk_r low here means this toggle is a rising edge.
            if (!sclk_r) begin
              sr_r      <= {sr_r[FRAME_BITS-2:0], bus.spi_miso};
              bit_cnt_r <= bit_cnt_r + 5'd1;
              if (bit_cnt_r == 5'(FRAME_BITS - 1)) begin
                cs_n_r  <= 1'b1;
                state_r <= ST_DONE;
              end else begin
                state_r <= ST_SHIFT;
              end
            end else begin
              sr_r <= sr_r;
            end
          end else begin
            hp_cnt_r <= hp_cnt_r + HP_W'(1);
          end
        end
        ST_DONE: begin
          cs_n_r  <= 1'b1;
          state_r <= ST_IDLE;
          if (lead_ok_s) begin
            sample_r       <= sr_r[11:0];
            sample_valid_r <= 1'b1;
          end else begin
            frame_err_r <= 1'b1;
          end
        end
        default: begin
          cs_n_r  <= 1'b1;
          sclk_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  reel_mic_sampler_envelope #(
    .DECAY_PERIOD (DECAY_PERIOD)
  ) u_envelope (
    .clk          (clk),
    .rst          (rst),
    .sample       (sample_r),
    .sample_valid (sample_valid_r),
    .reel         (reel_s)
  );

  assign bus.spi_cs_n     = cs_n_r;
  assign bus.spi_sclk     = sclk_r;
  assign bus.sample       = sample_r;
  assign bus.sample_valid = sample_valid_r;
  assign bus.frame_err    = frame_err_r;
  assign bus.reel         = reel_s;

endmodule
